pixel_stream_sequencer: RTL and testbench

Sequencer stage directly upstream of the 8-bit pixel ALU. On one command it streams a run of pixels from the source pixel memory and presents each pixel, an operand byte and the operation code to the ALU. It then writes each ALU result to the destination pixel memory. It owns all sequencing, pipelining and addressing, so the ALU stays purely combinational.

---
 rtl/pixel_pkg.sv | 32 +++
 rtl/pixel_key_rotator.sv | 41 ++++
 rtl/pixel_stream_sequencer.sv | 153 +++++++++++++++
 tb/tb_pixel_stream_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel stream sequencer: ALU op-codes, FSM states
// and the operand-byte conditioning used in front of the ALU.
package pixel_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift/rotate codes only ever see a 0..7 amount; code 0 gets a zero operand
  // because its result is taken from operand A, not from the ALU.
  function automatic logic [7:0] operand_byte(input logic [2:0] fun, input logic [7:0] raw);
    if (fun == OP_PASS)
      return 8'h00;
    else if (fun >= OP_SHR)
      return {5'b00000, raw[2:0]};
    else
      return raw;
  endfunction

endpackage

// File: rtl/pixel_key_rotator.sv
// Walks the 32-bit key one byte per pixel (byte 0 first) and conditions the
// selected byte for the current operation code.
module pixel_key_rotator
  import pixel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_advance,
  input  logic [31:0] i_key,
  input  logic [2:0]  i_fun,
  output logic [7:0]  o_operand
);

  logic [1:0] r_idx;
  logic [7:0] w_raw;

  // Byte index: restarts at 0 for each command, steps once per consumed pixel.
  always_ff @(posedge clk) begin
    if (rst)
      r_idx <= 2'd0;
    else if (i_clear)
      r_idx <= 2'd0;
    else if (i_advance)
      r_idx <= r_idx + 2'd1;
  end

  // Byte mux plus shift-amount masking.
  always_comb begin
    w_raw = 8'h00;
    case (r_idx)
      2'd0: w_raw = i_key[7:0];
      2'd1: w_raw = i_key[15:8];
      2'd2: w_raw = i_key[23:16];
      2'd3: w_raw = i_key[31:24];
      default: w_raw = 8'h00;
    endcase
    o_operand = operand_byte(i_fun, w_raw);
  end

endmodule

// File: rtl/pixel_stream_sequencer.sv
// Streams a run of pixels from source memory through the external
// combinational ALU and writes the results to destination memory.
// Pipeline: read issue -> data/operand capture -> result capture -> write.
module pixel_stream_sequencer
  import pixel_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_fun,
  input  logic [31:0]       cmd_key,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_fun,
  input  logic [7:0]        alu_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  state_t r_state, w_next;

  logic              w_accept;
  logic [7:0]        w_operand;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [2:0]        r_fun;
  logic [31:0]       r_key;
  logic              r_s2_vld;
  logic              r_s3_vld;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [7:0]        r_wr_data;
  logic              r_wr_en;

  assign w_accept = cmd_valid && cmd_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state: RUN ends on the last issued read, DRAIN ends once stages 2 and 3 are empty.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (cmd_len == '0) ? DONE : RUN;
      RUN:     if (r_remain == LEN_W'(1)) w_next = DRAIN;
      DRAIN:   if (!r_s2_vld && !r_s3_vld) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      RUN:     rd_en = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  pixel_key_rotator u_key_rotator (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_advance (r_s2_vld),
    .i_key     (r_key),
    .i_fun     (r_fun),
    .o_operand (w_operand)
  );

  // Command latch, address counters and the three pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_wr_ptr  <= '0;
      r_wr_addr <= '0;
      r_remain  <= '0;
      r_fun     <= 3'd0;
      r_key     <= 32'd0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_alu_a   <= 8'h00;
      r_alu_b   <= 8'h00;
      r_wr_data <= 8'h00;
      r_wr_en   <= 1'b0;
    end else begin
      r_s2_vld <= rd_en;
      r_s3_vld <= r_s2_vld;
      r_wr_en  <= r_s3_vld;

      if (w_accept) begin
        r_rd_addr <= cmd_src;
        r_remain  <= cmd_len;
        r_fun     <= cmd_fun;
        r_key     <= cmd_key;
      end else if (rd_en) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        r_remain  <= r_remain - LEN_W'(1);
      end

      if (r_s2_vld) begin
        r_alu_a <= rd_data;
        r_alu_b <= w_operand;
      end

      // Pass-through code ignores the ALU, whose output is undefined for it.
      if (w_accept) begin
        r_wr_ptr <= cmd_dst;
      end else if (r_s3_vld) begin
        r_wr_data <= (r_fun == OP_PASS) ? r_alu_a : alu_result;
        r_wr_addr <= r_wr_ptr;
        r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
      end
    end
  end

  assign rd_addr = r_rd_addr;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_fun = r_fun;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Self-checking bench for pixel_stream_sequencer: directed table, random
// commands against a transaction-level model, back-to-back and reset abort.
module tb_pixel_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src, cmd_dst, cmd_len;
  logic [2:0]  cmd_fun;
  logic [31:0] cmd_key;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_fun;
  logic [7:0]  alu_result;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done;

  pixel_stream_sequencer #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fun(cmd_fun),
    .cmd_key(cmd_key), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_result(alu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU behaviour (also drives the stand-in ALU).
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    logic [15:0] t;
    case (f)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a ^ b;
      3'd4: return a >> b[2:0];
      3'd5: return a << b[2:0];
      3'd6: begin t = {a, a} >> b[2:0]; return t[7:0]; end
      3'd7: begin t = {a, a} << b[2:0]; return t[15:8]; end
      default: return a ^ 8'h5A;  // code 0 is undefined: give something wrong on purpose
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_fun);

  logic [7:0] mem [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Event capture, sampled mid-cycle.
  logic [15:0] rd_q[$];
  int          rdc_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  int          done_q[$];
  int          acc_q[$];
  logic [7:0]  ab_hist [0:255];
  logic        rdy_hist [0:255];

  always @(negedge clk) begin
    if (rd_en) begin rd_q.push_back(rd_addr); rdc_q.push_back(cyc); end
    if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); wc_q.push_back(cyc); end
    if (done) done_q.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    ab_hist[cyc % 256]  <= alu_b;
    rdy_hist[cyc % 256] <= cmd_ready;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_operand(input logic [2:0] f, input logic [31:0] key, input int i);
    logic [31:0] s;
    s = key >> (8 * (i % 4));
    if (f == 3'd0) return 8'h00;
    if (f >= 3'd4) return {5'b00000, s[2:0]};
    return s[7:0];
  endfunction

  function automatic logic [7:0] ref_pixel(input logic [2:0] f, input logic [31:0] key,
                                           input logic [15:0] src, input int i);
    logic [7:0] a;
    a = mem[src + i[15:0]];
    if (f == 3'd0) return a;
    return alu_ref(a, ref_operand(f, key, i), f);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " rd_en"},     rd_en, 0);
    check({tag, " rd_addr"},   rd_addr, 0);
    check({tag, " wr_en"},     wr_en, 0);
    check({tag, " wr_addr"},   wr_addr, 0);
    check({tag, " wr_data"},   wr_data, 0);
    check({tag, " alu_a"},     alu_a, 0);
    check({tag, " alu_b"},     alu_b, 0);
    check({tag, " alu_fun"},   alu_fun, 0);
    check({tag, " busy"},      busy, 0);
    check({tag, " done"},      done, 0);
    check({tag, " cmd_ready"}, cmd_ready, 1);
  endtask

  // Compare one command's reads, writes, operands and done timing with the model.
  task automatic verify(input string tag, input logic [15:0] src, input logic [15:0] dst,
                        input int len, input logic [2:0] fun, input logic [31:0] key,
                        input int acc, input int dcy, input int rb, input int wb);
    logic [15:0] ea;
    for (int i = 0; i < len; i++) begin
      if (rb + i < rd_q.size()) begin
        ea = src + i[15:0];
        check({tag, " rd_addr"}, rd_q[rb + i], ea);
        check({tag, " rd_cycle"}, rdc_q[rb + i], acc + 1 + i);
      end
      if (wb + i < wa_q.size()) begin
        ea = dst + i[15:0];
        check({tag, " wr_addr"}, wa_q[wb + i], ea);
        check({tag, " wr_data"}, wd_q[wb + i], ref_pixel(fun, key, src, i));
        check({tag, " wr_cycle"}, wc_q[wb + i], acc + 4 + i);
      end
      check({tag, " alu_b"}, ab_hist[(acc + 3 + i) % 256], ref_operand(fun, key, i));
    end
    check({tag, " done_cycle"}, dcy, (len == 0) ? acc + 1 : acc + len + 4);
    check({tag, " ready_at_done"}, rdy_hist[dcy % 256], 0);
    check({tag, " ready_after_done"}, rdy_hist[(dcy + 1) % 256], 1);
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [2:0] fun, input logic [31:0] key,
                         output int wbase);
    int  rb, wb, db, ab, acc;
    bit  got;
    rb = rd_q.size(); wb = wa_q.size(); db = done_q.size(); ab = acc_q.size();
    wbase = wb;
    @(posedge clk); #1;
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fun = fun; cmd_key = key;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); #1; got = (acc_q.size() > ab); end
    check({tag, " accepted"}, got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!got) return;
    acc = acc_q[ab];
    got = 1'b0;
    for (int k = 0; k < int'(len) + 30 && !got; k++) begin @(negedge clk); #1; got = (done_q.size() > db); end
    check({tag, " done_seen"}, got, 1);
    if (!got) return;
    repeat (4) @(negedge clk);
    #1;
    check({tag, " rd_count"}, rd_q.size() - rb, len);
    check({tag, " wr_count"}, wa_q.size() - wb, len);
    check({tag, " done_count"}, done_q.size() - db, 1);
    check({tag, " alu_fun"}, alu_fun, fun);
    verify(tag, src, dst, int'(len), fun, key, acc, done_q[db], rb, wb);
  endtask

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [2:0]  fun;
    logic [31:0] key;
    logic [2:0]  nm;   // source bytes to preload
    logic [31:0] m;    // preload bytes, first at [7:0]
    logic [2:0]  ne;   // expected written bytes listed
    logic [47:0] e;    // expected bytes, first at [7:0]
  } vec_t;

  vec_t tbl [5];

  initial begin
    int wb, rb, db, ab, acc1, acc2, wb2, db2;
    bit got;
    logic [7:0] ev;

    tbl[0] = '{16'h0000, 16'h0100, 16'd4, 3'd1, 32'h0000_0001, 3'd4, 32'h0080_FF10, 3'd4, 48'h0000_0080_FF11};
    tbl[1] = '{16'h0200, 16'h0300, 16'd6, 3'd3, 32'hDDCC_BBAA, 3'd4, 32'h0000_0000, 3'd6, 48'hBBAA_DDCC_BBAA};
    tbl[2] = '{16'h0400, 16'h0500, 16'd1, 3'd6, 32'h0000_000B, 3'd1, 32'h0000_0001, 3'd1, 48'h0000_0000_0020};
    tbl[3] = '{16'h0600, 16'h0700, 16'd0, 3'd1, 32'h1234_5678, 3'd0, 32'h0000_0000, 3'd0, 48'h0};
    tbl[4] = '{16'hFFFE, 16'hFFFF, 16'd3, 3'd2, 32'h0000_0201, 3'd3, 32'h0007_0605, 3'd3, 48'h0000_0007_0404};

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fun = '0; cmd_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < int'(tbl[t].nm); j++) mem[tbl[t].src + j[15:0]] = tbl[t].m[8*j +: 8];
      run_cmd($sformatf("tbl%0d", t), tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].fun, tbl[t].key, wb);
      for (int j = 0; j < int'(tbl[t].ne); j++) begin
        ev = tbl[t].e[8*j +: 8];
        if (wb + j < wd_q.size()) check($sformatf("tbl%0d byte%0d", t, j), wd_q[wb + j], ev);
        else check($sformatf("tbl%0d byte%0d missing", t, j), 0, 1);
      end
    end

    // Random commands against the model.
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int n = 0; n < 30; n++) begin
      run_cmd($sformatf("rnd%0d", n), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40)),
              3'($urandom_range(0, 7)), $urandom, wb);
    end

    // Back-to-back: second command held valid through the first.
    rb = rd_q.size(); wb = wa_q.size(); db = done_q.size(); ab = acc_q.size();
    @(posedge clk); #1;
    cmd_src = 16'hFFFE; cmd_dst = 16'hFFFF; cmd_len = 16'd3; cmd_fun = 3'd5; cmd_key = 32'h0302_0100;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); #1; got = (acc_q.size() > ab); end
    check("b2b accept1", got, 1);
    @(posedge clk); #1;
    cmd_src = 16'h1000; cmd_dst = 16'h2000; cmd_len = 16'd5; cmd_fun = 3'd7; cmd_key = 32'h8844_2211;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); #1; got = (acc_q.size() > ab + 1); end
    check("b2b accept2", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); #1; got = (done_q.size() > db + 1); end
    check("b2b done2", got, 1);
    repeat (4) @(negedge clk);
    #1;
    check("b2b rd_count", rd_q.size() - rb, 8);
    check("b2b wr_count", wa_q.size() - wb, 8);
    check("b2b done_count", done_q.size() - db, 2);
    if (got && acc_q.size() >= ab + 2) begin
      acc1 = acc_q[ab]; acc2 = acc_q[ab + 1];
      check("b2b accept_after_done", acc2, done_q[db] + 1);
      verify("b2b1", 16'hFFFE, 16'hFFFF, 3, 3'd5, 32'h0302_0100, acc1, done_q[db], rb, wb);
      verify("b2b2", 16'h1000, 16'h2000, 5, 3'd7, 32'h8844_2211, acc2, done_q[db + 1], rb + 3, wb + 3);
    end

    // Reset held mid-RUN aborts the command.
    ab = acc_q.size();
    @(posedge clk); #1;
    cmd_src = 16'h3000; cmd_dst = 16'h4000; cmd_len = 16'd16; cmd_fun = 3'd1; cmd_key = 32'h0101_0101;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); #1; got = (acc_q.size() > ab); end
    check("abort accept", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort in_run rd_en", rd_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset("abort");
    wb2 = wa_q.size(); db2 = done_q.size();
    repeat (30) @(negedge clk);
    #1;
    check("abort no_writes", wa_q.size() - wb2, 0);
    check("abort no_done", done_q.size() - db2, 0);
    check("abort cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
